// File: rtl/sqrt_unit_param_pkg.sv
// Shared definitions for the parametrised square-root unit: FSM states and
// counter sizing.
package sqrt_unit_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/sqrt_unit_param_if.sv
// INIT/DONE handshake and operand/result bus of the square-root unit.
interface sqrt_unit_param_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 INIT;
  logic [WIDTH-1:0]     RADICAND;
  logic [WIDTH/2-1:0]   ROOT;
  logic [WIDTH/2:0]     REM;
  logic                 ZERO;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    output INIT, RADICAND,
    input  ROOT, REM, ZERO, BUSY, DONE
  );

  modport slave (
    input  INIT, RADICAND,
    output ROOT, REM, ZERO, BUSY, DONE
  );
endinterface

// File: rtl/sqrt_unit_param_step.sv
// One restoring digit-by-digit iteration: brings in the next two radicand bits
// and decides the next root bit.
module sqrt_unit_param_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH/2+1:0] rem_i,
  input  logic [WIDTH/2-1:0] root_i,
  input  logic [1:0]         top2_i,
  output logic [WIDTH/2+1:0] rem_o,
  output logic [WIDTH/2-1:0] root_o
);
  localparam int unsigned RW = WIDTH/2 + 2;

  logic [RW-1:0] t;
  logic [RW-1:0] trial;
  logic          ge;

  always_comb begin
    t      = (rem_i << 2) | RW'(top2_i);
    trial  = {root_i, 2'b01};
    ge     = (t >= trial);
    rem_o  = ge ? (t - trial) : t;
    root_o = {root_i[WIDTH/2-2:0], ge};
  end
endmodule

// File: rtl/sqrt_unit_param.sv
// Integer square root, one result bit per clock, with INIT/DONE handshake and
// a DONE hold window that INIT can cut short.
module sqrt_unit_param
  import sqrt_unit_param_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DONE_HOLD = 31
) (
  input  logic              CLK,
  input  logic              RST_N,
  sqrt_unit_param_if.slave  bus
);
  localparam int unsigned HW  = WIDTH / 2;
  localparam int unsigned RW  = HW + 2;
  localparam int unsigned CW  = cnt_width(HW);
  localparam int unsigned HCW = cnt_width(DONE_HOLD);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("sqrt_unit_param: WIDTH must be even and >= 4");
  end
  if (DONE_HOLD < 1) begin : g_bad_hold
    $error("sqrt_unit_param: DONE_HOLD must be >= 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q,  opnd_d;
  logic [HW-1:0]    wroot_q, wroot_d;
  logic [RW-1:0]    wrem_q,  wrem_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [HCW-1:0]   hold_q,  hold_d;
  logic [HW-1:0]    root_q,  root_d;
  logic [HW:0]      rem_q,   rem_d;
  logic             zero_q,  zero_d;
  logic             start;

  logic [RW-1:0]    step_rem;
  logic [HW-1:0]    step_root;

  sqrt_unit_param_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (wrem_q),
    .root_i (wroot_q),
    .top2_i (opnd_q[WIDTH-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    wroot_d = wroot_q;
    wrem_d  = wrem_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    root_d  = root_q;
    rem_d   = rem_q;
    zero_d  = zero_q;
    start   = 1'b0;

    case (state_q)
      ST_IDLE: start = bus.INIT;
      ST_CALC: begin
        wrem_d  = step_rem;
        wroot_d = step_root;
        opnd_d  = opnd_q << 2;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          hold_d  = HCW'(DONE_HOLD - 1);
          root_d  = step_root;
          rem_d   = (HW+1)'(step_rem);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        // A restart outranks hold expiry on the same edge.
        if (bus.INIT) begin
          start = 1'b1;
        end else if (hold_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d = ST_CALC;
      opnd_d  = bus.RADICAND;
      wroot_d = '0;
      wrem_d  = '0;
      cnt_d   = CW'(HW - 1);
      zero_d  = (bus.RADICAND == '0);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      opnd_q  <= '0;
      wroot_q <= '0;
      wrem_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      wroot_q <= wroot_d;
      wrem_q  <= wrem_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.ROOT = root_q;
  assign bus.REM  = rem_q;
  assign bus.ZERO = zero_q;
  assign bus.BUSY = (state_q == ST_CALC);
  assign bus.DONE = (state_q == ST_DONE);
endmodule

// File: tb/tb_sqrt_unit_param.sv
// Scoreboard bench for sqrt_unit_param: directed WIDTH=16 vectors and a
// WIDTH=32, DONE_HOLD=1 back-to-back sweep.
module tb_sqrt_unit_param;

  typedef struct {
    logic [31:0] root;
    logic [32:0] rem;
    logic        zero;
    int          done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  exp_t q16[$];
  exp_t q32[$];

  sqrt_unit_param_if #(.WIDTH(16)) if16 ();
  sqrt_unit_param_if #(.WIDTH(32)) if32 ();

  sqrt_unit_param #(.WIDTH(16), .DONE_HOLD(31)) u16 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (if16)
  );

  sqrt_unit_param #(.WIDTH(32), .DONE_HOLD(1)) u32 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (if32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DONE (t=%0t)", name, $time);
  endtask

  // Reference root by binary search on 64-bit squares.
  function automatic logic [31:0] isqrt_ref(input logic [31:0] x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= 64'(x)) lo = mid;
      else hi = mid;
    end
    return lo[31:0];
  endfunction

  // Monitors: pop and compare on every rising DONE.
  logic d16_prev = 1'b0;
  logic d32_prev = 1'b0;
  int   d32_len  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (if16.DONE && !d16_prev) begin
      if (q16.size() == 0) begin
        fail_timeout("w16_unexpected_done");
      end else begin
        e = q16.pop_front();
        chk("w16_root", 64'(if16.ROOT), 64'(e.root));
        chk("w16_rem", 64'(if16.REM), 64'(e.rem));
        chk("w16_zero", 64'(if16.ZERO), 64'(e.zero));
        chk("w16_latency", 64'(cyc), 64'(e.done_cyc));
        chk("w16_busy_in_done", 64'(if16.BUSY), 64'd0);
      end
    end
    d16_prev = if16.DONE;
  end

  always @(negedge clk) begin
    exp_t e;
    if (if32.DONE && !d32_prev) begin
      if (q32.size() == 0) begin
        fail_timeout("w32_unexpected_done");
      end else begin
        e = q32.pop_front();
        chk("w32_root", 64'(if32.ROOT), 64'(e.root));
        chk("w32_rem", 64'(if32.REM), 64'(e.rem));
        chk("w32_zero", 64'(if32.ZERO), 64'(e.zero));
        chk("w32_latency", 64'(cyc), 64'(e.done_cyc));
      end
    end
    if (if32.DONE) d32_len++;
    else if (d32_prev) begin
      chk("w32_done_len", 64'(d32_len), 64'd1);
      d32_len = 0;
    end
    d32_prev = if32.DONE;
  end

  // Drive INIT for exactly one accepting edge; caller is mid-cycle.
  task automatic start16(input logic [15:0] x, input logic [7:0] r, input logic [8:0] m,
                         input logic z, input bit push);
    exp_t e;
    if16.INIT     = 1'b1;
    if16.RADICAND = x;
    @(posedge clk);
    #1;
    if16.INIT = 1'b0;
    if (push) begin
      e.root     = 32'(r);
      e.rem      = 33'(m);
      e.zero     = z;
      e.done_cyc = cyc + 8;
      q16.push_back(e);
    end
  endtask

  task automatic wait_done16(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if16.DONE && n < 100);
    if (!if16.DONE) fail_timeout(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] ops[$];
    logic [31:0] x;
    exp_t        e;

    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    if16.INIT = 1'b0; if16.RADICAND = '0;
    if32.INIT = 1'b0; if32.RADICAND = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_root", 64'(if16.ROOT), 64'd0);
    chk("rst_rem", 64'(if16.REM), 64'd0);
    chk("rst_zero", 64'(if16.ZERO), 64'd0);
    chk("rst_busy", 64'(if16.BUSY), 64'd0);
    chk("rst_done", 64'(if16.DONE), 64'd0);
    rst_n = 1'b1;

    // 144 and the DONE hold window.
    @(negedge clk);
    start16(16'd144, 8'd12, 9'd0, 1'b0, 1'b1);
    chk("calc_busy", 64'(if16.BUSY), 64'd1);
    wait_done16("done_144");
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      if (!if16.DONE) break;
      n++;
    end
    chk("hold_len", 64'(n), 64'd31);
    chk("idle_busy", 64'(if16.BUSY), 64'd0);
    chk("idle_done", 64'(if16.DONE), 64'd0);
    chk("idle_root_held", 64'(if16.ROOT), 64'd12);

    // Boundaries, each restarted from DONE cycle 1.
    start16(16'hFFFF, 8'd255, 9'd510, 1'b0, 1'b1);
    wait_done16("done_ffff");
    start16(16'd0, 8'd0, 9'd0, 1'b1, 1'b1);
    wait_done16("done_0");
    start16(16'd1, 8'd1, 9'd0, 1'b0, 1'b1);
    wait_done16("done_1");

    // INIT during CALC must be ignored.
    start16(16'd200, 8'd14, 9'd4, 1'b0, 1'b1);
    @(negedge clk);
    if16.INIT = 1'b1; if16.RADICAND = 16'd50;
    @(posedge clk);
    #1 if16.INIT = 1'b0;
    wait_done16("done_200");

    // Reset in the third CALC cycle.
    start16(16'd1000, 8'd0, 9'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_root", 64'(if16.ROOT), 64'd0);
    chk("midrst_rem", 64'(if16.REM), 64'd0);
    chk("midrst_zero", 64'(if16.ZERO), 64'd0);
    chk("midrst_busy", 64'(if16.BUSY), 64'd0);
    chk("midrst_done", 64'(if16.DONE), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    start16(16'd1000, 8'd31, 9'd39, 1'b0, 1'b1);
    wait_done16("done_1000");

    // Restart in DONE hold cycle 5.
    repeat (4) @(posedge clk);
    #1;
    start16(16'd99, 8'd9, 9'd18, 1'b0, 1'b1);
    chk("restart_done_drop", 64'(if16.DONE), 64'd0);
    chk("restart_busy", 64'(if16.BUSY), 64'd1);
    wait_done16("done_99");

    // WIDTH=32 sweep with INIT held high: back-to-back restarts.
    ops.push_back(32'd0);
    ops.push_back(32'd1);
    ops.push_back(32'd2);
    ops.push_back(32'd4);
    ops.push_back(32'hFFFF_FFFF);
    ops.push_back(32'hFFFE_0001);
    ops.push_back(32'hFFFE_0000);
    while (ops.size() < 1000) ops.push_back($urandom() >> $urandom_range(0, 31));

    @(negedge clk);
    if32.RADICAND = ops[0];
    if32.INIT     = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      x          = ops[i];
      e.root     = isqrt_ref(x);
      e.rem      = 33'(64'(x) - 64'(e.root) * 64'(e.root));
      e.zero     = (x == 32'd0);
      e.done_cyc = cyc + 16;
      q32.push_back(e);
      if (i + 1 < 1000) begin
        if32.RADICAND = ops[i+1];
        repeat (16) @(posedge clk);
      end else begin
        if32.INIT = 1'b0;
      end
    end

    n = 0;
    while ((q16.size() != 0 || q32.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0 || q32.size() != 0) fail_timeout("drain");
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
